fetch_pc_ctrl: RTL and testbench

//  Fetch-stage PC generator for the P7 pipeline with a ready/valid handshake to a variable-latency

---
 rtl/fetch_pc_ctrl_pkg.sv | 22 ++
 rtl/fetch_pc_range_chk.sv | 14 +
 rtl/fetch_pc_ctrl.sv | 163 ++++++++++++++++
 tb/tb_fetch_pc_ctrl.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/fetch_pc_ctrl_pkg.sv
// Shared types and constants for the fetch-stage PC controller.
// Exception codes and FSM encodings live here so load/store checks can reuse them.
package fetch_pc_ctrl_pkg;

    localparam logic [4:0] EXC_NONE = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;

    typedef enum logic [1:0] {
        FETCH_ISSUE = 2'd0,
        FETCH_WAIT  = 2'd1,
        FETCH_HOLD  = 2'd2
    } fetch_state_e;

    // Ordered so that a numerically larger value outranks a smaller one.
    typedef enum logic [1:0] {
        PRIO_NONE     = 2'd0,
        PRIO_REDIRECT = 2'd1,
        PRIO_ERET     = 2'd2,
        PRIO_REQ      = 2'd3
    } ev_prio_e;

endpackage

// File: rtl/fetch_pc_range_chk.sv
// Combinational illegal-address check: misaligned or outside the text window.
// Kept separate so load/store address checks can instantiate the same logic.
module fetch_pc_range_chk #(
    parameter int unsigned           ADDR_W  = 32,
    parameter logic [ADDR_W-1:0]     TEXT_LO = ADDR_W'(32'h3000),
    parameter logic [ADDR_W-1:0]     TEXT_HI = ADDR_W'(32'h6ffc)
) (
    input  logic [ADDR_W-1:0] addr,
    output logic              bad
);

    assign bad = (addr[1:0] != 2'b00) || (addr < TEXT_LO) || (addr > TEXT_HI);

endmodule

// File: rtl/fetch_pc_ctrl.sv
// Fetch-stage PC generator with ready/valid handshake to a variable-latency imem.
// Priority: Req > eret > redirect > pending target > PC+4.
module fetch_pc_ctrl
    import fetch_pc_ctrl_pkg::*;
#(
    parameter int unsigned       ADDR_W      = 32,
    parameter logic [ADDR_W-1:0] RESET_VEC   = ADDR_W'(32'h3000),
    parameter logic [ADDR_W-1:0] HANDLER_VEC = ADDR_W'(32'h4180),
    parameter logic [ADDR_W-1:0] TEXT_LO     = ADDR_W'(32'h3000),
    parameter logic [ADDR_W-1:0] TEXT_HI     = ADDR_W'(32'h6ffc)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              Req,
    input  logic              eret,
    input  logic [ADDR_W-1:0] epc,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirectPc,
    input  logic              stall,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    output logic              fetch_valid,
    output logic [ADDR_W-1:0] pcOut,
    output logic [4:0]        ExcCode
);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] pend_pc_q, pend_pc_d;
    ev_prio_e          pend_prio_q, pend_prio_d;

    ev_prio_e          ev_prio;
    logic [ADDR_W-1:0] ev_pc;
    logic              ev;
    logic              take_ev;
    logic              squash;
    logic [ADDR_W-1:0] sq_pc;
    logic [ADDR_W-1:0] pc_seq;
    logic              bad;
    logic              done;

    fetch_pc_range_chk #(
        .ADDR_W  (ADDR_W),
        .TEXT_LO (TEXT_LO),
        .TEXT_HI (TEXT_HI)
    ) u_range_chk (
        .addr (pc_q),
        .bad  (bad)
    );

    always_comb begin
        ev_prio = PRIO_NONE;
        ev_pc   = pc_q;
        if (Req) begin
            ev_prio = PRIO_REQ;
            ev_pc   = HANDLER_VEC;
        end else if (eret) begin
            ev_prio = PRIO_ERET;
            ev_pc   = epc;
        end else if (redirect) begin
            ev_prio = PRIO_REDIRECT;
            ev_pc   = redirectPc;
        end
    end

    // A new event replaces the latched one unless the latched one outranks it.
    assign ev      = (ev_prio != PRIO_NONE);
    assign take_ev = ev && (ev_prio >= pend_prio_q);
    assign squash  = ev || (pend_prio_q != PRIO_NONE);
    assign sq_pc   = take_ev ? ev_pc : pend_pc_q;
    assign pc_seq  = pc_q + ADDR_W'(4);

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        pend_pc_d   = pend_pc_q;
        pend_prio_d = pend_prio_q;
        imem_req    = 1'b0;
        fetch_valid = 1'b0;
        done        = 1'b0;

        case (state_q)
            FETCH_ISSUE: begin
                if (bad) begin
                    done = 1'b1;
                end else begin
                    imem_req = 1'b1;
                    done     = imem_ack;
                    if (!imem_ack) begin
                        if (ev) begin
                            pc_d    = ev_pc;
                            state_d = FETCH_ISSUE;
                        end else begin
                            state_d = FETCH_WAIT;
                        end
                    end
                end
            end
            FETCH_WAIT: begin
                imem_req = 1'b1;
                done     = imem_ack;
                if (!imem_ack && take_ev) begin
                    pend_pc_d   = ev_pc;
                    pend_prio_d = ev_prio;
                end
            end
            FETCH_HOLD: begin
                if (ev) begin
                    pc_d    = ev_pc;
                    state_d = FETCH_ISSUE;
                end else begin
                    fetch_valid = 1'b1;
                    if (!stall) begin
                        pc_d    = pc_seq;
                        state_d = FETCH_ISSUE;
                    end
                end
            end
            default: state_d = FETCH_ISSUE;
        endcase

        if (done) begin
            pend_prio_d = PRIO_NONE;
            if (squash) begin
                pc_d    = sq_pc;
                state_d = FETCH_ISSUE;
            end else begin
                fetch_valid = 1'b1;
                if (stall) begin
                    state_d = FETCH_HOLD;
                end else begin
                    pc_d    = pc_seq;
                    state_d = FETCH_ISSUE;
                end
            end
        end

        if (reset) begin
            imem_req    = 1'b0;
            fetch_valid = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= FETCH_ISSUE;
            pc_q        <= RESET_VEC;
            pend_pc_q   <= RESET_VEC;
            pend_prio_q <= PRIO_NONE;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            pend_pc_q   <= pend_pc_d;
            pend_prio_q <= pend_prio_d;
        end
    end

    assign pcOut     = pc_q;
    assign imem_addr = pc_q;
    assign ExcCode   = bad ? EXC_ADEL : EXC_NONE;

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// Directed bench for fetch_pc_ctrl: inputs change on the falling edge,
// outputs are checked 1 time unit later, well clear of the rising edge.
module tb_fetch_pc_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        Req;
    logic        eret;
    logic [31:0] epc;
    logic        redirect;
    logic [31:0] redirectPc;
    logic        stall;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic        fetch_valid;
    logic [31:0] pcOut;
    logic [4:0]  ExcCode;

    int n_checks = 0;
    int n_pass   = 0;

    localparam logic [4:0] ADEL = 5'd4;
    localparam logic [4:0] NONE = 5'd0;

    fetch_pc_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .Req         (Req),
        .eret        (eret),
        .epc         (epc),
        .redirect    (redirect),
        .redirectPc  (redirectPc),
        .stall       (stall),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .fetch_valid (fetch_valid),
        .pcOut       (pcOut),
        .ExcCode     (ExcCode)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // One cycle: apply inputs at the falling edge, let them settle.
    task automatic drive(input logic rst, input logic rq, input logic er, input logic [31:0] ep,
                         input logic rd, input logic [31:0] rpc, input logic st, input logic ack);
        @(negedge clk);
        reset      = rst;
        Req        = rq;
        eret       = er;
        epc        = ep;
        redirect   = rd;
        redirectPc = rpc;
        stall      = st;
        imem_ack   = ack;
        #1;
    endtask

    task automatic plain(input logic st, input logic ack);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, st, ack);
    endtask

    task automatic expect_all(input string tag, input logic [31:0] pc, input logic req,
                              input logic fv, input logic [4:0] exc);
        chk({tag, ".pc"},   pcOut,       pc);
        chk({tag, ".addr"}, imem_addr,   pc);
        chk({tag, ".req"},  {31'd0, imem_req},    {31'd0, req});
        chk({tag, ".fv"},   {31'd0, fetch_valid}, {31'd0, fv});
        chk({tag, ".exc"},  {27'd0, ExcCode},     {27'd0, exc});
    endtask

    task automatic expect_reset(input string tag);
        chk({tag, ".req"}, {31'd0, imem_req},    32'd0);
        chk({tag, ".fv"},  {31'd0, fetch_valid}, 32'd0);
    endtask

    initial begin
        reset = 1'b1; Req = 1'b0; eret = 1'b0; epc = '0;
        redirect = 1'b0; redirectPc = '0; stall = 1'b0; imem_ack = 1'b0;

        drive(1'b1, 0, 0, 0, 0, 0, 0, 1'b1);
        expect_reset("rst0");
        drive(1'b1, 0, 0, 0, 0, 0, 0, 1'b1);
        expect_reset("rst1");

        // Zero-wait streaming, then a 2-cycle stall at 3008.
        plain(1'b0, 1'b1); expect_all("seq0", 32'h3000, 1, 1, NONE);
        plain(1'b0, 1'b1); expect_all("seq1", 32'h3004, 1, 1, NONE);
        plain(1'b1, 1'b1); expect_all("stl0", 32'h3008, 1, 1, NONE);
        plain(1'b1, 1'b1); expect_all("stl1", 32'h3008, 0, 1, NONE);
        plain(1'b0, 1'b1); expect_all("stl2", 32'h3008, 0, 1, NONE);
        plain(1'b0, 1'b1); expect_all("seq2", 32'h300c, 1, 1, NONE);

        // Reset, then ack delayed three cycles at 3000.
        drive(1'b1, 0, 0, 0, 0, 0, 0, 1'b0);
        expect_reset("rst2");
        plain(1'b0, 1'b0); expect_all("wt0", 32'h3000, 1, 0, NONE);
        plain(1'b0, 1'b0); expect_all("wt1", 32'h3000, 1, 0, NONE);
        plain(1'b0, 1'b0); expect_all("wt2", 32'h3000, 1, 0, NONE);
        plain(1'b0, 1'b1); expect_all("wt3", 32'h3000, 1, 1, NONE);

        // Redirect latched mid-WAIT at 3004 squashes the fetch.
        plain(1'b0, 1'b0); expect_all("rdw0", 32'h3004, 1, 0, NONE);
        drive(1'b0, 0, 0, 0, 1'b1, 32'h3100, 0, 1'b0);
        expect_all("rdw1", 32'h3004, 1, 0, NONE);
        plain(1'b0, 1'b1); expect_all("rdw2", 32'h3004, 1, 0, NONE);
        plain(1'b0, 1'b1); expect_all("rdw3", 32'h3100, 1, 1, NONE);

        // Redirect then Req in the same WAIT: Req wins.
        plain(1'b0, 1'b0); expect_all("rq0", 32'h3104, 1, 0, NONE);
        drive(1'b0, 0, 0, 0, 1'b1, 32'h3100, 0, 1'b0);
        expect_all("rq1", 32'h3104, 1, 0, NONE);
        drive(1'b0, 1'b1, 0, 0, 0, 0, 0, 1'b0);
        expect_all("rq2", 32'h3104, 1, 0, NONE);
        plain(1'b0, 1'b1); expect_all("rq3", 32'h3104, 1, 0, NONE);
        plain(1'b0, 1'b1); expect_all("rq4", 32'h4180, 1, 1, NONE);

        // Req and eret together in ISSUE, then eret alone.
        drive(1'b0, 1'b1, 1'b1, 32'h3200, 0, 0, 0, 1'b1);
        expect_all("rqe0", 32'h4184, 1, 0, NONE);
        plain(1'b0, 1'b1); expect_all("rqe1", 32'h4180, 1, 1, NONE);
        drive(1'b0, 0, 1'b1, 32'h3200, 0, 0, 0, 1'b1);
        expect_all("er0", 32'h4184, 1, 0, NONE);
        plain(1'b0, 1'b1); expect_all("er1", 32'h3200, 1, 1, NONE);

        // Illegal fetch addresses: misaligned, above and below the text window.
        drive(1'b0, 0, 0, 0, 1'b1, 32'h3002, 0, 1'b1);
        expect_all("ad0", 32'h3204, 1, 0, NONE);
        plain(1'b0, 1'b0); expect_all("ad1", 32'h3002, 0, 1, ADEL);
        drive(1'b0, 0, 0, 0, 1'b1, 32'h7000, 0, 1'b0);
        expect_all("ad2", 32'h3006, 0, 0, ADEL);
        plain(1'b0, 1'b0); expect_all("ad3", 32'h7000, 0, 1, ADEL);
        drive(1'b0, 0, 0, 0, 1'b1, 32'h2ffc, 0, 1'b0);
        expect_all("ad4", 32'h7004, 0, 0, ADEL);
        plain(1'b0, 1'b0); expect_all("ad5", 32'h2ffc, 0, 1, ADEL);
        drive(1'b0, 0, 0, 0, 1'b1, 32'h6ffc, 0, 1'b1);
        expect_all("ad6", 32'h3000, 1, 0, NONE);
        plain(1'b0, 1'b1); expect_all("ad7", 32'h6ffc, 1, 1, NONE);
        drive(1'b0, 0, 0, 0, 1'b1, 32'h3000, 0, 1'b0);
        expect_all("ad8", 32'h7000, 0, 0, ADEL);

        // Reset while a redirect is pending in WAIT.
        plain(1'b0, 1'b0); expect_all("rw0", 32'h3000, 1, 0, NONE);
        drive(1'b0, 0, 0, 0, 1'b1, 32'h3100, 0, 1'b0);
        expect_all("rw1", 32'h3000, 1, 0, NONE);
        drive(1'b1, 0, 0, 0, 0, 0, 0, 1'b1);
        expect_reset("rw2");
        plain(1'b0, 1'b1); expect_all("rw3", 32'h3000, 1, 1, NONE);
        plain(1'b0, 1'b1); expect_all("rw4", 32'h3004, 1, 1, NONE);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
